// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
package hazard_pkg;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } slot_t;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Width of a forward select / slot index for a scoreboard of the given depth.
    function automatic int sel_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID-stage source register against the scoreboard slots that
// are still ahead of writeback and reports the nearest producer.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int IDX_W    = sel_width(DEPTH)
) (
    input  logic [4:0]       src,
    input  logic             use_src,
    input  slot_t            slots [DEPTH],
    output logic             match,
    output logic [IDX_W-1:0] idx,
    output logic             load_hit
);

    // WB (slot DEPTH-1) is not compared: the register file writes through.
    localparam int NCMP = DEPTH - 1;

    logic [NCMP-1:0] hit_vec;
    logic [NCMP-1:0] load_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NCMP; gi++) begin : g_cmp
            // x0 never matches because a source of 0 is rejected outright.
            assign hit_vec[gi]  = use_src && (src != 5'd0) && slots[gi].valid &&
                                  slots[gi].regwrite && (slots[gi].rd == src);
            // Load still too young to supply its data.
            assign load_vec[gi] = hit_vec[gi] && slots[gi].is_load && (gi < LOAD_LAT);
        end
    endgenerate

    assign match    = |hit_vec;
    assign load_hit = |load_vec;

    // Priority encoder: scanning from the oldest down lets the youngest producer win.
    always_comb begin
        idx = '0;
        for (int k = NCMP - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard that tracks destination registers from EX to WB
// and derives load-use stalls, branch flushes and EX operand forward selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        id_valid_i,
    input  logic [4:0]                  id_rs1_i,
    input  logic [4:0]                  id_rs2_i,
    input  logic                        id_use_rs1_i,
    input  logic                        id_use_rs2_i,
    input  logic [4:0]                  id_rd_i,
    input  logic                        id_regwrite_i,
    input  logic                        id_memread_i,
    input  logic                        br_taken_i,
    output logic                        stall_o,
    output logic                        flush_o,
    output logic                        ex_valid_o,
    output logic [sel_width(DEPTH)-1:0] ex_fwd1_o,
    output logic [sel_width(DEPTH)-1:0] ex_fwd2_o,
    output logic [CNT_W-1:0]            stall_cnt_o,
    output logic [CNT_W-1:0]            flush_cnt_o
);

    localparam int SEL_W = sel_width(DEPTH);

    slot_t slots_reg [DEPTH];

    logic [1:0][SEL_W-1:0] ex_fwd_reg;
    logic [1:0][SEL_W-1:0] ex_fwd_next;
    logic [CNT_W-1:0]      stall_cnt_reg;
    logic [CNT_W-1:0]      stall_cnt_next;
    logic [CNT_W-1:0]      flush_cnt_reg;
    logic [CNT_W-1:0]      flush_cnt_next;

    logic [1:0][4:0]       src_addr;
    logic [1:0]            src_use;
    logic [1:0]            src_match;
    logic [1:0]            src_load_hit;
    logic [1:0][SEL_W-1:0] src_idx;

    logic flush;
    logic stall;
    logic insert;

    assign src_addr = {id_rs2_i, id_rs1_i};
    assign src_use  = {id_use_rs2_i, id_use_rs1_i};

    // A taken branch squashes everything younger; reset masks it so in-flight
    // state is simply discarded.
    assign flush  = !rst_i && br_taken_i && slots_reg[BR_STAGE].valid;
    // Flush has priority: the stalled instruction is being squashed anyway.
    assign stall  = !rst_i && id_valid_i && (|src_load_hit) && !flush;
    assign insert = id_valid_i && !stall && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic stall_covered;

            hazard_match #(
                .DEPTH    (DEPTH),
                .LOAD_LAT (LOAD_LAT),
                .IDX_W    (SEL_W)
            ) u_match (
                .src      (src_addr[gi]),
                .use_src  (src_use[gi]),
                .slots    (slots_reg),
                .match    (src_match[gi]),
                .idx      (src_idx[gi]),
                .load_hit (src_load_hit[gi])
            );

            // A nearest producer that is a young load cannot forward; the stall
            // holds the consumer until the load moves out of the window.
            assign stall_covered = (int'(src_idx[gi]) < LOAD_LAT) &&
                                   slots_reg[src_idx[gi]].is_load;

            // Slot k feeds the EX mux on input k+1 once the consumer reaches EX.
            assign ex_fwd_next[gi] = !insert ? SEL_W'(FWD_RF) :
                                     (src_match[gi] && !stall_covered) ?
                                     SEL_W'(int'(src_idx[gi]) + 1) : SEL_W'(FWD_RF);
        end
    endgenerate

    // Saturating event counters.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        if (flush && (flush_cnt_reg != {CNT_W{1'b1}})) begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
        end
    end

    // Advance the scoreboard, insert the ID instruction or a bubble, and
    // register the forward selects alongside it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots_reg[k] <= '0;
            end
            ex_fwd_reg    <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                slots_reg[k] <= slots_reg[k-1];
            end
            // Instructions that were younger than the branch land in 1..BR_STAGE.
            if (flush) begin
                for (int k = 1; k <= BR_STAGE; k++) begin
                    slots_reg[k].valid <= 1'b0;
                end
            end
            if (insert) begin
                slots_reg[0] <= '{valid: 1'b1, rd: id_rd_i,
                                  regwrite: id_regwrite_i, is_load: id_memread_i};
            end else begin
                slots_reg[0] <= '0;
            end
            ex_fwd_reg    <= ex_fwd_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign stall_o     = stall;
    assign flush_o     = flush;
    assign ex_valid_o  = slots_reg[0].valid;
    assign ex_fwd1_o   = ex_fwd_reg[0];
    assign ex_fwd2_o   = ex_fwd_reg[1];
    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance A uses the default geometry, instance B uses
// DEPTH=5, LOAD_LAT=2 with 2-bit counters. Both share the same stimulus.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_use1, id_use2, id_rw, id_mr, br;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall_a, flush_a, exv_a;
    logic [1:0]  f1_a, f2_a;
    logic [15:0] sc_a, fc_a;

    logic        stall_b, flush_b, exv_b;
    logic [2:0]  f1_b, f2_b;
    logic [1:0]  sc_b, fc_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .BR_STAGE(1), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
        .id_rd_i(id_rd), .id_regwrite_i(id_rw), .id_memread_i(id_mr),
        .br_taken_i(br), .stall_o(stall_a), .flush_o(flush_a), .ex_valid_o(exv_a),
        .ex_fwd1_o(f1_a), .ex_fwd2_o(f2_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(2), .BR_STAGE(1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2),
        .id_rd_i(id_rd), .id_regwrite_i(id_rw), .id_memread_i(id_mr),
        .br_taken_i(br), .stall_o(stall_b), .flush_o(flush_b), .ex_valid_o(exv_b),
        .ex_fwd1_o(f1_b), .ex_fwd2_o(f2_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input string name, input logic v,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
        id_rd = rd; id_rw = rw; id_mr = mr;
        $display("[%0t] ID <= %s", $time, name);
    endtask

    task automatic idle(input int cycles);
        issue("bubble", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        br = 1'b0;
        issue("bubble", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_stall", stall_a, 0);
        chk("rst_flush", flush_a, 0);
        chk("rst_exv", exv_a, 0);
        chk("rst_fwd1", f1_a, 0);
        chk("rst_fwd2", f2_a, 0);
        chk("rst_stall_cnt", sc_a, 0);
        chk("rst_flush_cnt", fc_a, 0);
        rst = 1'b0;

        // ALU -> ALU back to back: forward from slot 0
        issue("add x5,x1,x2", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        settle();
        chk("alu_p_stall", stall_a, 0);
        tick();
        issue("sub x6,x5,x3", 1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        settle();
        chk("alu_c_stall", stall_a, 0);
        tick();
        chk("alu_exv", exv_a, 1);
        chk("alu_fwd1", f1_a, 1);
        chk("alu_fwd2", f2_a, 0);
        idle(3);

        // Load-use: one stall cycle, then forward from slot 1
        issue("lw x5,0(x1)", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
        settle();
        tick();
        issue("add x6,x5,x5", 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
        settle();
        chk("lu_stall_on", stall_a, 1);
        tick();
        chk("lu_bubble_exv", exv_a, 0);
        chk("lu_stall_cnt", sc_a, 1);
        chk("lu_stall_off", stall_a, 0);
        tick();
        chk("lu_exv", exv_a, 1);
        chk("lu_fwd1", f1_a, 2);
        chk("lu_fwd2", f2_a, 2);
        chk("lu_stall_cnt_hold", sc_a, 1);
        idle(3);

        // x0 never forwards
        issue("addi x0,x0,1", 1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
        settle();
        tick();
        issue("add x8,x0,x0", 1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0);
        settle();
        chk("x0_stall", stall_a, 0);
        tick();
        chk("x0_exv", exv_a, 1);
        chk("x0_fwd1", f1_a, 0);
        chk("x0_fwd2", f2_a, 0);
        idle(3);

        // Two producers of x7 in flight: youngest wins
        issue("add x7,x1,x2", 1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
        settle();
        tick();
        issue("addi x7,x7,4", 1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 0);
        settle();
        tick();
        issue("add x9,x7,x0", 1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0);
        settle();
        chk("near_stall", stall_a, 0);
        tick();
        chk("near_fwd1", f1_a, 1);
        idle(3);

        // Taken branch in slot 1 while ID holds a load-use hazard
        issue("beq x1,x2", 1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0);
        settle();
        tick();
        issue("lw x9,0(x3)", 1, 5'd3, 1, 5'd0, 0, 5'd9, 1, 1);
        settle();
        tick();
        issue("add x10,x9,x9 (branch taken)", 1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0);
        br = 1'b1;
        settle();
        chk("br_flush", flush_a, 1);
        chk("br_stall", stall_a, 0);
        tick();
        chk("br_exv", exv_a, 0);
        chk("br_flush_cnt", fc_a, 1);
        chk("br_stall_cnt", sc_a, 1);
        issue("add x11,x9,x0 (br still high)", 1, 5'd9, 1, 5'd0, 0, 5'd11, 1, 0);
        settle();
        chk("br_slot1_invalid_flush", flush_a, 0);
        chk("br_after_stall", stall_a, 0);
        tick();
        br = 1'b0;
        chk("br_after_exv", exv_a, 1);
        chk("br_squashed_fwd1", f1_a, 0);
        idle(3);

        // Reset in the middle of a stall
        issue("lw x11,0(x1)", 1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 1);
        settle();
        tick();
        issue("add x12,x11,x0", 1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0);
        settle();
        chk("rs_stall_on", stall_a, 1);
        rst = 1'b1;
        settle();
        chk("rs_stall_forced", stall_a, 0);
        tick();
        rst = 1'b0;
        settle();
        chk("rs_stall_after", stall_a, 0);
        chk("rs_exv", exv_a, 0);
        chk("rs_fwd1", f1_a, 0);
        chk("rs_stall_cnt", sc_a, 0);
        chk("rs_flush_cnt", fc_a, 0);
        chk("rs_b_stall_cnt", sc_b, 0);
        idle(5);

        // DEPTH=5, LOAD_LAT=2: two stall cycles, forward from slot 2
        issue("lw x12,0(x1)", 1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1);
        settle();
        tick();
        issue("add x13,x12,x0", 1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0);
        settle();
        chk("b_stall_c1", stall_b, 1);
        tick();
        chk("b_exv_c1", exv_b, 0);
        chk("b_stall_c2", stall_b, 1);
        tick();
        chk("b_exv_c2", exv_b, 0);
        chk("b_stall_end", stall_b, 0);
        chk("b_stall_cnt", sc_b, 2);
        tick();
        chk("b_exv", exv_b, 1);
        chk("b_fwd1", f1_b, 3);
        idle(5);

        // Second load-use on B drives the 2-bit counter into saturation
        issue("lw x14,0(x1)", 1, 5'd1, 1, 5'd0, 0, 5'd14, 1, 1);
        settle();
        tick();
        issue("add x15,x14,x0", 1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0);
        settle();
        chk("b2_stall_c1", stall_b, 1);
        tick();
        tick();
        chk("b2_stall_end", stall_b, 0);
        chk("b2_stall_cnt_sat", sc_b, 3);
        tick();
        chk("b2_fwd1", f1_b, 3);
        chk("b2_stall_cnt_hold", sc_b, 3);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
